// File: rtl/tl_ul_pkg.sv
// tl_ul_pkg: shared TileLink-UL opcodes, arbiter state and beat-count helper
package tl_ul_pkg;

    localparam int TL_DATA_W   = 64;
    localparam int TL_MAX_SIZE = 6;
    localparam int BEAT_LG2    = $clog2(TL_DATA_W / 8);
    localparam int BEATS_W     = TL_MAX_SIZE - BEAT_LG2 + 1;

    localparam logic [2:0] GET           = 3'd4;
    localparam logic [2:0] PUTFULL       = 3'd0;
    localparam logic [2:0] PUTPARTIAL    = 3'd1;
    localparam logic [2:0] ACCESSACK     = 3'd0;
    localparam logic [2:0] ACCESSACKDATA = 3'd1;

    typedef enum logic {IDLE, LOCK} arb_state_e;

    // Oversized requests are clamped to the largest legal size rather than rejected.
    function automatic logic [BEATS_W-1:0] beats_of(input logic [2:0] opcode, input logic [3:0] size);
        logic [3:0] s;
        s = (size > 4'(TL_MAX_SIZE)) ? 4'(TL_MAX_SIZE) : size;
        beats_of = (!opcode[2] && s > 4'(BEAT_LG2)) ? BEATS_W'(1) << (s - 4'(BEAT_LG2)) : BEATS_W'(1);
    endfunction

endpackage

// File: rtl/tl_rr_lock_arb.sv
// tl_rr_lock_arb: two-client round-robin arbiter that locks onto a client for a multi-beat message
module tl_rr_lock_arb
    import tl_ul_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [1:0]     valid,
    input  logic           fire,
    input  logic [CNT_W:0] beats,
    output logic           sel,
    output logic           lock
);

    arb_state_e       state, state_n;
    logic             rr_pri, rr_pri_n;
    logic             owner, owner_n;
    logic [CNT_W-1:0] beats_left, beats_left_n;

    // state register; reset drops any burst in progress and favours client 0
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            rr_pri     <= 1'b0;
            owner      <= 1'b0;
            beats_left <= '0;
        end else begin
            state      <= state_n;
            rr_pri     <= rr_pri_n;
            owner      <= owner_n;
            beats_left <= beats_left_n;
        end
    end

    // grant choice plus burst bookkeeping; priority flips only when a whole message completes
    always_comb begin
        state_n      = state;
        rr_pri_n     = rr_pri;
        owner_n      = owner;
        beats_left_n = beats_left;
        lock         = state == LOCK;
        sel          = lock ? owner : (valid[rr_pri] ? rr_pri : ~rr_pri);
        case (state)
            IDLE: if (fire) begin
                if (beats == (CNT_W+1)'(1)) begin
                    rr_pri_n = ~sel;
                end else begin
                    state_n      = LOCK;
                    owner_n      = sel;
                    beats_left_n = CNT_W'(beats - 1'b1);
                end
            end
            LOCK: if (fire) begin
                beats_left_n = beats_left - 1'b1;
                if (beats_left == CNT_W'(1)) begin
                    state_n  = IDLE;
                    rr_pri_n = ~owner;
                end
            end
        endcase
    end

endmodule

// File: rtl/tl_ul_arbiter_2to1.sv
// tl_ul_arbiter_2to1: merges two TL-UL clients onto one manager port, tagging source with the client index
module tl_ul_arbiter_2to1
    import tl_ul_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 32,
    parameter int SRC_W    = 4,
    parameter int MAX_SIZE = 6
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                in0_a_valid,
    output logic                in0_a_ready,
    input  logic [2:0]          in0_a_bits_opcode,
    input  logic [2:0]          in0_a_bits_param,
    input  logic [3:0]          in0_a_bits_size,
    input  logic [SRC_W-1:0]    in0_a_bits_source,
    input  logic [ADDR_W-1:0]   in0_a_bits_address,
    input  logic [DATA_W/8-1:0] in0_a_bits_mask,
    input  logic [DATA_W-1:0]   in0_a_bits_data,
    input  logic                in0_a_bits_corrupt,

    input  logic                in1_a_valid,
    output logic                in1_a_ready,
    input  logic [2:0]          in1_a_bits_opcode,
    input  logic [2:0]          in1_a_bits_param,
    input  logic [3:0]          in1_a_bits_size,
    input  logic [SRC_W-1:0]    in1_a_bits_source,
    input  logic [ADDR_W-1:0]   in1_a_bits_address,
    input  logic [DATA_W/8-1:0] in1_a_bits_mask,
    input  logic [DATA_W-1:0]   in1_a_bits_data,
    input  logic                in1_a_bits_corrupt,

    output logic                in0_d_valid,
    input  logic                in0_d_ready,
    output logic [2:0]          in0_d_bits_opcode,
    output logic [1:0]          in0_d_bits_param,
    output logic [3:0]          in0_d_bits_size,
    output logic [SRC_W-1:0]    in0_d_bits_source,
    output logic [3:0]          in0_d_bits_sink,
    output logic                in0_d_bits_denied,
    output logic [DATA_W-1:0]   in0_d_bits_data,
    output logic                in0_d_bits_corrupt,

    output logic                in1_d_valid,
    input  logic                in1_d_ready,
    output logic [2:0]          in1_d_bits_opcode,
    output logic [1:0]          in1_d_bits_param,
    output logic [3:0]          in1_d_bits_size,
    output logic [SRC_W-1:0]    in1_d_bits_source,
    output logic [3:0]          in1_d_bits_sink,
    output logic                in1_d_bits_denied,
    output logic [DATA_W-1:0]   in1_d_bits_data,
    output logic                in1_d_bits_corrupt,

    output logic                out_a_valid,
    input  logic                out_a_ready,
    output logic [2:0]          out_a_bits_opcode,
    output logic [2:0]          out_a_bits_param,
    output logic [3:0]          out_a_bits_size,
    output logic [SRC_W:0]      out_a_bits_source,
    output logic [ADDR_W-1:0]   out_a_bits_address,
    output logic [DATA_W/8-1:0] out_a_bits_mask,
    output logic [DATA_W-1:0]   out_a_bits_data,
    output logic                out_a_bits_corrupt,

    input  logic                out_d_valid,
    output logic                out_d_ready,
    input  logic [2:0]          out_d_bits_opcode,
    input  logic [1:0]          out_d_bits_param,
    input  logic [3:0]          out_d_bits_size,
    input  logic [SRC_W:0]      out_d_bits_source,
    input  logic [3:0]          out_d_bits_sink,
    input  logic                out_d_bits_denied,
    input  logic [DATA_W-1:0]   out_d_bits_data,
    input  logic                out_d_bits_corrupt
);

    localparam int CNT_W = MAX_SIZE - BEAT_LG2;

    logic           sel, lock, fire, tgt;
    logic [CNT_W:0] beats;

    tl_rr_lock_arb #(.CNT_W(CNT_W)) u_arb (
        .clock (clock),
        .reset (reset),
        .valid ({in1_a_valid, in0_a_valid}),
        .fire  (fire),
        .beats (beats),
        .sel   (sel),
        .lock  (lock)
    );

    // A channel: payload follows the grant; handshakes are held off while in reset
    always_comb begin
        out_a_valid        = reset & (sel ? in1_a_valid : in0_a_valid);
        in0_a_ready        = reset & out_a_ready & ~sel;
        in1_a_ready        = reset & out_a_ready & sel;
        fire               = out_a_valid & out_a_ready;
        out_a_bits_opcode  = sel ? in1_a_bits_opcode  : in0_a_bits_opcode;
        out_a_bits_param   = sel ? in1_a_bits_param   : in0_a_bits_param;
        out_a_bits_size    = sel ? in1_a_bits_size    : in0_a_bits_size;
        out_a_bits_source  = {sel, sel ? in1_a_bits_source : in0_a_bits_source};
        out_a_bits_address = sel ? in1_a_bits_address : in0_a_bits_address;
        out_a_bits_mask    = sel ? in1_a_bits_mask    : in0_a_bits_mask;
        out_a_bits_data    = sel ? in1_a_bits_data    : in0_a_bits_data;
        out_a_bits_corrupt = sel ? in1_a_bits_corrupt : in0_a_bits_corrupt;
        beats              = (CNT_W+1)'(beats_of(out_a_bits_opcode, out_a_bits_size));
    end

    // D channel: steer by the source MSB added on the A side, then strip it
    always_comb begin
        tgt                = out_d_bits_source[SRC_W];
        in0_d_valid        = out_d_valid & ~tgt;
        in1_d_valid        = out_d_valid & tgt;
        out_d_ready        = tgt ? in1_d_ready : in0_d_ready;
        in0_d_bits_opcode  = out_d_bits_opcode;
        in0_d_bits_param   = out_d_bits_param;
        in0_d_bits_size    = out_d_bits_size;
        in0_d_bits_source  = out_d_bits_source[SRC_W-1:0];
        in0_d_bits_sink    = out_d_bits_sink;
        in0_d_bits_denied  = out_d_bits_denied;
        in0_d_bits_data    = out_d_bits_data;
        in0_d_bits_corrupt = out_d_bits_corrupt;
        in1_d_bits_opcode  = out_d_bits_opcode;
        in1_d_bits_param   = out_d_bits_param;
        in1_d_bits_size    = out_d_bits_size;
        in1_d_bits_source  = out_d_bits_source[SRC_W-1:0];
        in1_d_bits_sink    = out_d_bits_sink;
        in1_d_bits_denied  = out_d_bits_denied;
        in1_d_bits_data    = out_d_bits_data;
        in1_d_bits_corrupt = out_d_bits_corrupt;
    end

endmodule

// File: tb/tb_tl_ul_arbiter_2to1.sv
// tb_tl_ul_arbiter_2to1: directed and randomized checks of the 2:1 TL-UL arbiter against a message-level model
module tb_tl_ul_arbiter_2to1;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 32;
    localparam int SRC_W  = 4;
    localparam int MW     = DATA_W / 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic [1:0]        a_valid = '0;
    logic [2:0]        a_op    [2];
    logic [2:0]        a_param [2];
    logic [3:0]        a_size  [2];
    logic [SRC_W-1:0]  a_src   [2];
    logic [ADDR_W-1:0] a_addr  [2];
    logic [MW-1:0]     a_mask  [2];
    logic [DATA_W-1:0] a_data  [2];
    logic              a_corr  [2];
    logic              in0_a_ready, in1_a_ready;

    logic              out_a_valid, out_a_ready = 1'b0;
    logic [2:0]        o_op, o_param;
    logic [3:0]        o_size;
    logic [SRC_W:0]    o_src;
    logic [ADDR_W-1:0] o_addr;
    logic [MW-1:0]     o_mask;
    logic [DATA_W-1:0] o_data;
    logic              o_corr;

    logic              d_valid = 1'b0, out_d_ready;
    logic [2:0]        d_op = '0;
    logic [1:0]        d_param = '0;
    logic [3:0]        d_size = '0, d_sink = '0;
    logic [SRC_W:0]    d_src = '0;
    logic              d_denied = 1'b0, d_corr = 1'b0;
    logic [DATA_W-1:0] d_data = '0;
    logic              in0_d_ready = 1'b0, in1_d_ready = 1'b0;
    logic              in0_d_valid, in1_d_valid;
    logic [2:0]        i0_op, i1_op;
    logic [1:0]        i0_param, i1_param;
    logic [3:0]        i0_size, i1_size, i0_sink, i1_sink;
    logic [SRC_W-1:0]  i0_src, i1_src;
    logic              i0_den, i1_den, i0_corr, i1_corr;
    logic [DATA_W-1:0] i0_data, i1_data;

    int checks = 0;
    int errors = 0;

    tl_ul_arbiter_2to1 dut (
        .clock(clock), .reset(reset),
        .in0_a_valid(a_valid[0]), .in0_a_ready(in0_a_ready),
        .in0_a_bits_opcode(a_op[0]), .in0_a_bits_param(a_param[0]), .in0_a_bits_size(a_size[0]),
        .in0_a_bits_source(a_src[0]), .in0_a_bits_address(a_addr[0]), .in0_a_bits_mask(a_mask[0]),
        .in0_a_bits_data(a_data[0]), .in0_a_bits_corrupt(a_corr[0]),
        .in1_a_valid(a_valid[1]), .in1_a_ready(in1_a_ready),
        .in1_a_bits_opcode(a_op[1]), .in1_a_bits_param(a_param[1]), .in1_a_bits_size(a_size[1]),
        .in1_a_bits_source(a_src[1]), .in1_a_bits_address(a_addr[1]), .in1_a_bits_mask(a_mask[1]),
        .in1_a_bits_data(a_data[1]), .in1_a_bits_corrupt(a_corr[1]),
        .in0_d_valid(in0_d_valid), .in0_d_ready(in0_d_ready),
        .in0_d_bits_opcode(i0_op), .in0_d_bits_param(i0_param), .in0_d_bits_size(i0_size),
        .in0_d_bits_source(i0_src), .in0_d_bits_sink(i0_sink), .in0_d_bits_denied(i0_den),
        .in0_d_bits_data(i0_data), .in0_d_bits_corrupt(i0_corr),
        .in1_d_valid(in1_d_valid), .in1_d_ready(in1_d_ready),
        .in1_d_bits_opcode(i1_op), .in1_d_bits_param(i1_param), .in1_d_bits_size(i1_size),
        .in1_d_bits_source(i1_src), .in1_d_bits_sink(i1_sink), .in1_d_bits_denied(i1_den),
        .in1_d_bits_data(i1_data), .in1_d_bits_corrupt(i1_corr),
        .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
        .out_a_bits_opcode(o_op), .out_a_bits_param(o_param), .out_a_bits_size(o_size),
        .out_a_bits_source(o_src), .out_a_bits_address(o_addr), .out_a_bits_mask(o_mask),
        .out_a_bits_data(o_data), .out_a_bits_corrupt(o_corr),
        .out_d_valid(d_valid), .out_d_ready(out_d_ready),
        .out_d_bits_opcode(d_op), .out_d_bits_param(d_param), .out_d_bits_size(d_size),
        .out_d_bits_source(d_src), .out_d_bits_sink(d_sink), .out_d_bits_denied(d_denied),
        .out_d_bits_data(d_data), .out_d_bits_corrupt(d_corr)
    );

    // message-level reference: remaining beats of the message on the wire, its owner, favoured client
    int m_rem, m_owner, m_fav;
    int c_left [2];

    function automatic int ref_beats(input int op, input int size);
        int s;
        s = size > 6 ? 6 : size;
        return (op < 4 && (1 << s) > MW) ? (1 << s) / MW : 1;
    endfunction

    function automatic int m_sel(input logic [1:0] v);
        if (m_rem > 0) return m_owner;
        return v[m_fav] ? m_fav : 1 - m_fav;
    endfunction

    task automatic m_fire(input int s, input int beats);
        if (m_rem == 0) begin
            if (beats == 1) m_fav = 1 - s;
            else begin
                m_rem   = beats - 1;
                m_owner = s;
            end
        end else begin
            m_rem--;
            if (m_rem == 0) m_fav = 1 - m_owner;
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_client(input int k, input logic [2:0] op, input logic [3:0] size, input logic [SRC_W-1:0] src);
        a_op[k]    = op;
        a_size[k]  = size;
        a_src[k]   = src;
        a_param[k] = 3'(k + 1);
        a_addr[k]  = 32'h1000 * (k + 1);
        a_mask[k]  = '1;
        a_data[k]  = 64'(k);
        a_corr[k]  = 1'b0;
    endtask

    task automatic new_msg(input int k);
        int r;
        r = $urandom_range(0, 2);
        a_op[k]    = r == 2 ? 3'd4 : 3'(r);
        a_size[k]  = 4'($urandom_range(0, 7));
        a_src[k]   = 4'($urandom);
        a_param[k] = 3'($urandom);
        a_addr[k]  = $urandom;
        a_corr[k]  = 1'($urandom);
        c_left[k]  = ref_beats(int'(a_op[k]), int'(a_size[k]));
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        a_valid     = '0;
        d_valid     = 1'b0;
        out_a_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset   = 1'b1;
        m_rem   = 0;
        m_owner = 0;
        m_fav   = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        set_client(0, 3'd4, 4'd3, 4'h5);
        set_client(1, 3'd4, 4'd3, 4'ha);
        a_valid     = 2'b11;
        out_a_ready = 1'b1;
        d_valid     = 1'b1;
        d_src       = 5'h12;
        repeat (3) begin
            @(posedge clock);
            #2;
            checks++;
            if ({out_a_valid, in0_a_ready, in1_a_ready} !== 3'b000) begin
                errors++;
                $display("FAIL reset_gate got %b want 000", {out_a_valid, in0_a_ready, in1_a_ready});
            end
        end
        checks++;
        if ({in1_d_valid, in0_d_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_d_route got %b want 10", {in1_d_valid, in0_d_valid});
        end
        d_valid = 1'b0;
        reset   = 1'b1;
        #1;
        checks++;
        if ({out_a_valid, in0_a_ready, in1_a_ready, o_src} !== {3'b110, 5'h05}) begin
            errors++;
            $display("FAIL reset_first_grant got %b/%h want 110/05", {out_a_valid, in0_a_ready, in1_a_ready}, o_src);
        end
        @(posedge clock);
        #2;
        checks++;
        if ({out_a_valid, in0_a_ready, in1_a_ready, o_src} !== {3'b101, 5'h1a}) begin
            errors++;
            $display("FAIL reset_second_grant got %b/%h want 101/1a", {out_a_valid, in0_a_ready, in1_a_ready}, o_src);
        end
        step();
    endtask

    task automatic test_burst_lock();
        do_reset();
        set_client(0, 3'd0, 4'd6, 4'h2);
        set_client(1, 3'd4, 4'd2, 4'h7);
        a_valid     = 2'b11;
        out_a_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_data[0] = 64'(i) * 64'h0101_0101_0101_0101;
            #1;
            checks++;
            if ({out_a_valid, in0_a_ready, in1_a_ready, o_src} !== {3'b110, 5'h02} || o_data !== 64'(i) * 64'h0101_0101_0101_0101) begin
                errors++;
                $display("FAIL burst_beat%0d got %b/%h/%h want 110/02/%h", i, {out_a_valid, in0_a_ready, in1_a_ready}, o_src, o_data, 64'(i) * 64'h0101_0101_0101_0101);
            end
            step();
        end
        a_valid[0] = 1'b0;
        #1;
        checks++;
        if ({out_a_valid, in1_a_ready, o_src} !== {2'b11, 5'h17}) begin
            errors++;
            $display("FAIL burst_then_get got %b/%h want 11/17", {out_a_valid, in1_a_ready}, o_src);
        end
        step();
    endtask

    task automatic test_stall_burst();
        int fires;
        fires = 0;
        do_reset();
        set_client(0, 3'd0, 4'd6, 4'h1);
        set_client(1, 3'd4, 4'd0, 4'h9);
        a_valid = 2'b11;
        for (int c = 0; c < 40 && fires < 8; c++) begin
            a_valid[0]  = !(c == 4 || c == 5);
            out_a_ready = (c % 2) == 0;
            #1;
            checks++;
            if ({in1_a_ready, out_a_valid} !== {1'b0, a_valid[0]} || (out_a_valid && o_src !== 5'h01)) begin
                errors++;
                $display("FAIL stall_lock c%0d got rdy1=%b v=%b src=%h want 0/%b/01", c, in1_a_ready, out_a_valid, o_src, a_valid[0]);
            end
            if (out_a_valid && out_a_ready) fires++;
            step();
        end
        checks++;
        if (fires != 8) begin
            errors++;
            $display("FAIL stall_fires got %0d want 8", fires);
        end
        a_valid     = 2'b11;
        a_op[0]     = 3'd4;
        out_a_ready = 1'b1;
        #1;
        checks++;
        if (o_src !== 5'h19) begin
            errors++;
            $display("FAIL stall_rr_pri got %h want 19", o_src);
        end
        step();
    endtask

    task automatic test_d_route();
        logic [DATA_W+17:0] got, want;
        d_valid     = 1'b1;
        d_src       = 5'h13;
        in0_d_ready = 1'b1;
        in1_d_ready = 1'b0;
        #1;
        checks++;
        if ({in1_d_valid, in0_d_valid, out_d_ready, i1_src} !== {3'b100, 4'h3}) begin
            errors++;
            $display("FAIL d_route got %b/%h want 100/3", {in1_d_valid, in0_d_valid, out_d_ready}, i1_src);
        end
        in1_d_ready = 1'b1;
        #1;
        checks++;
        if (out_d_ready !== 1'b1) begin
            errors++;
            $display("FAIL d_ready got %b want 1", out_d_ready);
        end
        for (int i = 0; i < 20; i++) begin
            d_valid     = 1'($urandom);
            d_op        = 3'($urandom);
            d_param     = 2'($urandom);
            d_size      = 4'($urandom);
            d_src       = 5'($urandom);
            d_sink      = 4'($urandom);
            d_denied    = 1'($urandom);
            d_corr      = 1'($urandom);
            d_data      = {$urandom, $urandom};
            in0_d_ready = 1'($urandom);
            in1_d_ready = 1'($urandom);
            #1;
            want = {d_op, d_param, d_size, d_src[3:0], d_sink, d_denied, d_data, d_corr};
            got  = d_src[4] ? {i1_op, i1_param, i1_size, i1_src, i1_sink, i1_den, i1_data, i1_corr}
                            : {i0_op, i0_param, i0_size, i0_src, i0_sink, i0_den, i0_data, i0_corr};
            checks++;
            if ({in0_d_valid, in1_d_valid, out_d_ready} !== {d_valid & ~d_src[4], d_valid & d_src[4], d_src[4] ? in1_d_ready : in0_d_ready} || got !== want) begin
                errors++;
                $display("FAIL d_rand%0d got %b/%h want %b/%h", i, {in0_d_valid, in1_d_valid, out_d_ready}, got,
                         {d_valid & ~d_src[4], d_valid & d_src[4], d_src[4] ? in1_d_ready : in0_d_ready}, want);
            end
        end
        d_valid = 1'b0;
    endtask

    task automatic test_fairness();
        int n [2];
        n = '{0, 0};
        do_reset();
        set_client(0, 3'd4, 4'd3, 4'h3);
        set_client(1, 3'd4, 4'd3, 4'hc);
        a_valid     = 2'b11;
        out_a_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++;
            if (out_a_valid !== 1'b1 || o_src !== (i % 2 == 0 ? 5'h03 : 5'h1c)) begin
                errors++;
                $display("FAIL fair_cycle%0d got %b/%h want 1/%h", i, out_a_valid, o_src, i % 2 == 0 ? 5'h03 : 5'h1c);
            end
            if (out_a_valid === 1'b1 && o_src[4] !== 1'bx) n[o_src[4]]++;
            step();
        end
        checks++;
        if (n[0] != 10 || n[1] != 10) begin
            errors++;
            $display("FAIL fair_counts got %0d/%0d want 10/10", n[0], n[1]);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_client(0, 3'd0, 4'd6, 4'h4);
        set_client(1, 3'd4, 4'd3, 4'h6);
        a_valid     = 2'b11;
        out_a_ready = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        #1;
        checks++;
        if ({out_a_valid, in0_a_ready, in1_a_ready} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_gate got %b want 000", {out_a_valid, in0_a_ready, in1_a_ready});
        end
        step();
        reset   = 1'b1;
        a_op[0] = 3'd4;
        #1;
        checks++;
        if ({out_a_valid, in0_a_ready, o_src} !== {2'b11, 5'h04}) begin
            errors++;
            $display("FAIL midrst_grant0 got %b/%h want 11/04", {out_a_valid, in0_a_ready}, o_src);
        end
        step();
        checks++;
        if ({out_a_valid, in1_a_ready, o_src} !== {2'b11, 5'h16}) begin
            errors++;
            $display("FAIL midrst_idle got %b/%h want 11/16", {out_a_valid, in1_a_ready}, o_src);
        end
        step();
    endtask

    task automatic test_random();
        int s;
        logic ev;
        logic [1:0] done;
        logic [DATA_W+ADDR_W+MW+14+SRC_W:0] got, want;
        do_reset();
        new_msg(0);
        new_msg(1);
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 2; k++) begin
                a_valid[k] = $urandom_range(0, 3) != 0;
                a_data[k]  = {$urandom, $urandom};
                a_mask[k]  = 8'($urandom);
            end
            out_a_ready = $urandom_range(0, 3) != 0;
            d_valid     = 1'($urandom);
            d_src       = 5'($urandom);
            #1;
            s  = m_sel(a_valid);
            ev = a_valid[s];
            checks++;
            if ({out_a_valid, in0_a_ready, in1_a_ready} !== {ev, s == 0 && out_a_ready, s == 1 && out_a_ready}
                || {in0_d_valid, in1_d_valid} !== {d_valid & ~d_src[4], d_valid & d_src[4]}) begin
                errors++;
                $display("FAIL rand_hs c%0d got %b want %b", c, {out_a_valid, in0_a_ready, in1_a_ready, in0_d_valid, in1_d_valid},
                         {ev, s == 0 && out_a_ready, s == 1 && out_a_ready, d_valid & ~d_src[4], d_valid & d_src[4]});
            end
            if (ev) begin
                want = {a_op[s], a_param[s], a_size[s], 1'(s), a_src[s], a_addr[s], a_mask[s], a_data[s], a_corr[s]};
                got  = {o_op, o_param, o_size, o_src, o_addr, o_mask, o_data, o_corr};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL rand_payload c%0d got %h want %h", c, got, want);
                end
            end
            done = '0;
            if (ev && out_a_ready) begin
                m_fire(s, ref_beats(int'(a_op[s]), int'(a_size[s])));
                c_left[s]--;
                if (c_left[s] == 0) done[s] = 1'b1;
            end
            step();
            for (int k = 0; k < 2; k++) if (done[k]) new_msg(k);
        end
        a_valid = '0;
        d_valid = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) set_client(k, 3'd4, 4'd0, '0);
        test_reset();
        test_burst_lock();
        test_stall_burst();
        test_d_route();
        test_fairness();
        test_reset_mid_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tl_ul_arbiter_2to1.md
Name: tl_ul_arbiter_2to1

Overview:
- Merges two TileLink-UL client ports onto one manager port, upstream of the existing single-port TL pass-through xbar stage.
- A channel: round-robin arbitration with burst lock, so multi-beat Put messages are never interleaved.
- Source IDs are widened by one bit carrying the client index.
- D channel: responses are routed back to the issuing client by that bit, and the bit is stripped.

Parameters:
- DATA_W, 64, data width in bits; beat = DATA_W/8 bytes.
- ADDR_W, 32, address width.
- SRC_W, 4, client source width; manager source width = SRC_W+1.
- MAX_SIZE, 6, largest legal lg2 transfer size (64 B = 8 beats); sets beat-counter width.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- inK_a_valid / inK_a_ready  in/out  1  client K A handshake (K = 0,1).
- inK_a_bits_{opcode 3, param 3, size 4, source SRC_W, address ADDR_W, mask DATA_W/8, data DATA_W, corrupt 1}  in  client K A payload.
- inK_d_valid / inK_d_ready  out/in  1  client K D handshake.
- inK_d_bits_{opcode 3, param 2, size 4, source SRC_W, sink 4, denied 1, data DATA_W, corrupt 1}  out  client K D payload.
- out_a_valid / out_a_ready  out/in  1  manager A handshake.
- out_a_bits_{same fields as inK_a_bits, source SRC_W+1}  out  manager A payload.
- out_d_valid / out_d_ready  in/out  1  manager D handshake.
- out_d_bits_{same fields as inK_d_bits, source SRC_W+1}  in  manager D payload.

Behaviour:
- State: fsm in {IDLE, LOCK}; owner (1b); rr_pri (1b, the client favoured on a tie); beats_left (MAX_SIZE-3 bits).
- Reset (reset==0 at a clock edge):
  - Registers: fsm=IDLE, rr_pri=0, owner=0, beats_left=0.
  - While reset is low, in0/in1_a_ready=0 and out_a_valid=0; D routing stays combinational.
- Beat count: beats = (opcode[2]==0 && size>3) ? 1<<(size-3) : 1.
  - PutFull (0) and PutPartial (1) carry data; Get and other opcodes are 1 beat.
  - size>MAX_SIZE is illegal; the block treats it as MAX_SIZE and does not check it.
- IDLE:
  - sel = rr_pri if in[rr_pri]_a_valid, else the other client.
  - out_a_valid = in0_a_valid|in1_a_valid. Payload from sel; out source = {sel, in_sel_source}.
  - in[sel]_a_ready = out_a_ready; the non-selected client's ready=0.
  - The grant is combinational, zero added latency, no bubble.
- IDLE, on out_a fire:
  - beats==1: stay IDLE, rr_pri <= ~sel.
  - beats>1: fsm <= LOCK, owner <= sel, beats_left <= beats-1.
- LOCK:
  - Only the owner is muxed through; the other client's ready=0 even if out_a_ready=1.
  - Each fire decrements beats_left. The fire at beats_left==1 returns to IDLE with rr_pri <= ~owner.
  - The owner deasserting valid mid-burst holds the lock (no timeout).
- Fairness: with both clients continuously valid, messages strictly alternate 0,1,0,1. A starved client waits at most one maximum-length message.
- D channel, purely combinational:
  - tgt = out_d_bits_source[SRC_W].
  - in[tgt]_d_valid = out_d_valid; the other client's d_valid=0.
  - out_d_ready = in[tgt]_d_ready.
  - inK_d_bits_source = out_d_bits_source[SRC_W-1:0]; other fields pass through.
  - AccessAckData bursts need no lock; each beat carries its source.
- Simultaneous events: A and D are independent. D fire never affects A state. Same-cycle fires on both channels are legal.
- Reset mid-burst: the lock is abandoned, and the next post-reset grant goes to client 0. Upstream must also be reset.

Decomposition:
- Shared package tl_ul_pkg:
  - opcode constants (GET=4, PUTFULL=0, PUTPARTIAL=1, ACCESSACK=0, ACCESSACKDATA=1);
  - fsm state enum;
  - function beats_of(opcode,size);
  - localparam BEAT_LG2 = $clog2(DATA_W/8).
- One sub-module, tl_rr_lock_arb: owns fsm, rr_pri, owner, beats_left.
  - Inputs: valid[1:0], fire, beats.
  - Outputs: sel, lock.
  - The top level holds only the payload muxes and D demux.

Test Plan:
1. Reset low 3 cycles with both clients valid and out_a_ready=1 → out_a_valid=0, both a_ready=0. Release reset with both issuing Get → first grant client 0, out source 0x0_ & src0; next cycle client 1, source 0x10|src1.
2. Client 0 PutFull size=6 (8 beats) and client 1 Get both valid → 8 consecutive client-0 beats, in1_a_ready=0 throughout, then the client-1 Get on cycle 9.
3. Client 0 burst with out_a_ready toggling 1,0,1,0 and valid dropping for 2 cycles mid-burst → lock holds, exactly 8 fires, then rr_pri=1.
4. out_d source=0x13, valid=1, in1_d_ready=0 → in1_d_valid=1, in0_d_valid=0, out_d_ready=0, in1_d_bits_source=0x3. Raise in1_d_ready → out_d_ready=1.
5. Both clients always valid with 1-beat Gets for 20 cycles → grants alternate exactly 10/10, starting with client 0.
6. Reset asserted after beat 3 of 8 → post-reset fsm=IDLE, and the first grant goes to client 0 even if client 1 is also valid.
